load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface.
- Accepts one load/store request at a time from the execute stage.
- Converts byte addresses to word addresses and performs sub-word stores as read-modify-write, because the data memory is word-only.
- Extracts and sign- or zero-extends load data, flags misaligned and out-of-range accesses, and returns one response per request over a valid/ready handshake.

Parameters:
- MEM_DEPTH_LOG2, 10, log2 of data-memory depth in 32-bit words; legal byte addresses are 0 .. 4*2^MEM_DEPTH_LOG2 - 1.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_address  in  32  byte address
- req_store_data  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_load_data  out  32  extended load result; 0 for stores and faults
- resp_misaligned  out  1  H/HU with addr[0]=1, or W with addr[1:0]!=0
- resp_fault  out  1  illegal funct3, or address >= 4*2^MEM_DEPTH_LOG2
- mem_read_enable  out  1  to data memory
- mem_write_enable  out  1  to data memory
- mem_address  out  32  word index = {2'b00, addr[31:2]}
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  combinational read data from memory

Interface (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (reset_n low, any state): FSM to IDLE; all request and data registers to 0. Outputs: req_ready=1 once reset_n is high; resp_valid=0, resp_load_data=0, resp_misaligned=0, resp_fault=0, mem_read_enable=0, mem_write_enable=0, mem_address=0, mem_write_data=0.
- A request in flight when reset asserts is dropped. No memory write occurs after reset asserts.
- States: IDLE, LOAD, RMW_READ, STORE, RESP.
- IDLE: req_ready=1. On req_valid, latch is_store, funct3, address and store_data, then:
  - misaligned or fault -> RESP with the corresponding flag; no memory access at all.
  - load -> LOAD.
  - SW -> STORE.
  - SB/SH -> RMW_READ.
- Request decode priority: fault is checked before misaligned. A store with funct3 100/101 is a fault.
- LOAD (1 cycle): mem_read_enable=1, mem_address=word index. On the clock edge, capture the lane selected by addr[1:0] (byte) or addr[1] (half). B/H sign-extend; BU/HU zero-extend; W passes through. Next state RESP.
- RMW_READ (1 cycle): mem_read_enable=1. On the clock edge, merge store_data[7:0] into byte lane addr[1:0] (SB) or store_data[15:0] into half lane addr[1] (SH); other lanes keep the read value. Next state STORE.
- STORE (1 cycle): mem_write_enable=1, mem_write_data = merged word (SW: store_data unmodified). Next state RESP.
- mem_read_enable and mem_write_enable are never both high in the same cycle; both are 0 in IDLE and RESP.
- RESP: resp_valid=1 and response fields are held stable until resp_ready is seen high on a clock edge; then IDLE. A new request is not accepted in the same cycle a response completes.
- Latency, request accept edge to resp_valid: load 2 cycles, SW 2 cycles, SB/SH 3 cycles, fault/misaligned 1 cycle.
- resp_ready may be held high permanently. Back-to-back throughput for loads is one request per 3 cycles.

Decomposition:
- Shared package `lsu_pkg`:
  - funct3 width constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum encoding;
  - a lane-select helper function.
- One sub-module, `load_align_extend`: combinational lane extraction plus sign/zero extension. It is reused later by the writeback stage.
- Store merge stays inline in the top module.

Test Plan:
- Memory word 5 = 32'h80FF_7F01. LB addr 0x14 -> 32'h0000_0001; LB 0x16 -> 32'hFFFF_FFFF; LBU 0x16 -> 32'h0000_00FF; LH 0x16 -> 32'hFFFF_80FF; LHU 0x16 -> 32'h0000_80FF. Each response arrives 2 cycles after accept.
- Word 3 = 32'h1122_3344; SB addr 0x0D data 32'hAAAA_AA55 -> memory word 3 = 32'h1122_5544. Exactly one read cycle then one write cycle; resp at 3 cycles.
- SH 0x0E data 32'h0000_BEEF on word 3 = 32'h1122_3344 -> 32'hBEEF_3344. SW 0x0C data 32'hDEAD_BEEF -> written with no read cycle.
- LW 0x02 -> resp_misaligned=1, resp_load_data=0, no mem enable pulses. LH 0x1001 -> resp_fault=1 (fault wins). Store with funct3=100 -> resp_fault=1.
- Hold resp_ready low 5 cycles after a load: resp_valid and resp_load_data stay stable and req_ready=0. Deassert reset_n during RMW_READ: mem_write_enable never asserts and the memory word is unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store path: RV32I width codes, FSM encoding
// and the byte-lane shift used by both load extraction and store merging.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_RMW_READ = 3'd2;
  localparam logic [2:0] ST_STORE    = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

  // Bit offset of the addressed lane within a 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [2:0] funct3, input logic [1:0] byte_off);
    logic [4:0] sh;
    case (funct3)
      F3_B, F3_BU: sh = {byte_off, 3'b000};
      F3_H, F3_HU: sh = {byte_off[1], 4'b0000};
      default:     sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Combinational lane extraction and sign/zero extension of a memory word.
// Shared with the writeback stage.
module load_align_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  assign lane = word_i >> lane_shift(funct3_i, byte_off_i);

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      F3_W:    data_o = lane;
      F3_BU:   data_o = {24'd0, lane[7:0]};
      F3_HU:   data_o = {16'd0, lane[15:0]};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, word-only memory, sub-word
// stores done as read-modify-write, one response per request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_load_data,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  logic [2:0]  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] word_q, word_d;
  logic [31:0] load_data_q, load_data_d;
  logic        misaligned_q, misaligned_d;
  logic        fault_q, fault_d;

  logic        legal_f3, out_of_range, dec_fault, dec_misaligned;
  logic [31:0] load_ext, lane_mask, merged;
  logic [4:0]  merge_sh;

  always_comb begin
    if (req_is_store)
      legal_f3 = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    else
      legal_f3 = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                 (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
  end

  assign out_of_range   = |req_address[31:MEM_DEPTH_LOG2+2];
  assign dec_fault      = !legal_f3 || out_of_range;
  // Fault takes priority, so misaligned is only reported on otherwise-legal requests.
  assign dec_misaligned = !dec_fault &&
                          ((((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_address[0]) ||
                           ((req_funct3 == F3_W) && (req_address[1:0] != 2'b00)));

  load_align_extend u_align (
    .funct3_i   (funct3_q),
    .byte_off_i (addr_q[1:0]),
    .word_i     (mem_read_data),
    .data_o     (load_ext)
  );

  assign merge_sh  = lane_shift(funct3_q, addr_q[1:0]);
  assign lane_mask = ((funct3_q == F3_H) ? 32'h0000_FFFF : 32'h0000_00FF) << merge_sh;
  assign merged    = (mem_read_data & ~lane_mask) | ((store_data_q << merge_sh) & lane_mask);

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    word_d       = word_q;
    load_data_d  = load_data_q;
    misaligned_d = misaligned_q;
    fault_d      = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          funct3_d     = req_funct3;
          addr_d       = req_address;
          store_data_d = req_store_data;
          word_d       = req_store_data;
          load_data_d  = 32'd0;
          fault_d      = dec_fault;
          misaligned_d = dec_misaligned;
          if (dec_fault || dec_misaligned) state_d = ST_RESP;
          else if (!req_is_store)          state_d = ST_LOAD;
          else if (req_funct3 == F3_W)     state_d = ST_STORE;
          else                             state_d = ST_RMW_READ;
        end
      end
      ST_LOAD: begin
        load_data_d = load_ext;
        state_d     = ST_RESP;
      end
      ST_RMW_READ: begin
        word_d  = merged;
        state_d = ST_STORE;
      end
      ST_STORE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      funct3_q     <= 3'd0;
      addr_q       <= 32'd0;
      store_data_q <= 32'd0;
      word_q       <= 32'd0;
      load_data_q  <= 32'd0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      word_q       <= word_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
    end
  end

  assign req_ready        = reset_n && (state_q == ST_IDLE);
  assign resp_valid       = (state_q == ST_RESP);
  assign resp_load_data   = load_data_q;
  assign resp_misaligned  = misaligned_q;
  assign resp_fault       = fault_q;
  assign mem_read_enable  = (state_q == ST_LOAD) || (state_q == ST_RMW_READ);
  assign mem_write_enable = (state_q == ST_STORE);
  assign mem_address      = {2'b00, addr_q[31:2]};
  assign mem_write_data   = word_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed checks of load_store_unit against a byte-level
// reference model of the data memory and the access rules.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_store_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_load_data;
  logic        resp_misaligned, resp_fault;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = 10'd0;
  logic [31:0] poke_val = 32'd0;

  int n_cmp = 0, n_bad = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;

  load_store_unit #(.MEM_DEPTH_LOG2(10)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_address      (req_address),
    .req_store_data   (req_store_data),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_load_data   (resp_load_data),
    .resp_misaligned  (resp_misaligned),
    .resp_fault       (resp_fault),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'hDEAD_DEAD;

  always @(posedge clock) begin
    if (mem_read_enable)  rd_cnt <= rd_cnt + 1;
    if (mem_write_enable) wr_cnt <= wr_cnt + 1;
    if (mem_read_enable && mem_write_enable) both_cnt <= both_cnt + 1;
    if (mem_write_enable && (mem_address < 32'd1024)) mem[mem_address[9:0]] <= mem_write_data;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    @(negedge clock);
    poke_en  = 1'b1;
    poke_idx = idx[9:0];
    poke_val = v;
    @(negedge clock);
    poke_en  = 1'b0;
    ref_mem[idx] = v;
  endtask

  function automatic int access_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Reference: access rules expressed in bytes, memory kept as an array of words.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] e_data,
                       output logic e_mis, output logic e_fault,
                       output int e_lat, output int e_rd, output int e_wr);
    int size, off, widx;
    logic [31:0] w, mask;
    size    = access_size(f3);
    e_fault = (size == 0) || (st && f3[2]) || (a >= 32'd4096);
    e_mis   = !e_fault && ((a % size) != 0);
    e_data  = 32'd0;
    e_rd    = 0;
    e_wr    = 0;
    off     = int'(a % 4);
    widx    = int'(a / 4);
    if (e_fault || e_mis) begin
      e_lat = 1;
    end else if (!st) begin
      e_lat = 2;
      e_rd  = 1;
      w     = ref_mem[widx] >> (8 * off);
      mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      w     = w & mask;
      if (!f3[2] && size < 4 && w[8 * size - 1]) w = w | ~mask;
      e_data = w;
    end else begin
      e_lat = (size == 4) ? 2 : 3;
      e_rd  = (size == 4) ? 0 : 1;
      e_wr  = 1;
      w     = ref_mem[widx];
      for (int k = 0; k < size; k++) w[8 * (off + k) +: 8] = d[8 * k +: 8];
      ref_mem[widx] = w;
    end
  endtask

  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input int hold,
                        output logic [31:0] got);
    logic [31:0] e_data;
    logic        e_mis, e_fault;
    int          e_lat, e_rd, e_wr, rd0, wr0, lat, n;
    model(st, f3, a, d, e_data, e_mis, e_fault, e_lat, e_rd, e_wr);
    @(negedge clock);
    req_valid      = 1'b1;
    req_is_store   = st;
    req_funct3     = f3;
    req_address    = a;
    req_store_data = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_val({tag, ":ready"}, {31'd0, req_ready}, 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 10);
    check_val({tag, ":latency"}, lat, e_lat);
    check_val({tag, ":data"}, resp_load_data, e_data);
    check_val({tag, ":misaligned"}, {31'd0, resp_misaligned}, {31'd0, e_mis});
    check_val({tag, ":fault"}, {31'd0, resp_fault}, {31'd0, e_fault});
    got = resp_load_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check_val({tag, ":hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check_val({tag, ":hold_data"}, resp_load_data, e_data);
      check_val({tag, ":hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check_val({tag, ":resp_done"}, {31'd0, resp_valid}, 32'd0);
    check_val({tag, ":reads"}, rd_cnt - rd0, e_rd);
    check_val({tag, ":writes"}, wr_cnt - wr0, e_wr);
    if (e_wr != 0) check_val({tag, ":mem"}, mem[a[11:2]], ref_mem[a[11:2]]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a;
    int wr0, r;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_address = 32'd0; req_store_data = 32'd0; resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_val("rst:resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst:load_data", resp_load_data, 32'd0);
    check_val("rst:flags", {30'd0, resp_misaligned, resp_fault}, 32'd0);
    check_val("rst:mem_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    check_val("rst:mem_address", mem_address, 32'd0);
    check_val("rst:mem_wdata", mem_write_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check_val("rst:req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 32; i++) poke(i, $urandom);

    poke(5, 32'h80FF_7F01);
    do_req("lb_14", 1'b0, 3'b000, 32'h14, 32'd0, 0, got);  check_val("tp:lb_14", got, 32'h0000_0001);
    do_req("lb_16", 1'b0, 3'b000, 32'h16, 32'd0, 0, got);  check_val("tp:lb_16", got, 32'hFFFF_FFFF);
    do_req("lbu_16", 1'b0, 3'b100, 32'h16, 32'd0, 0, got); check_val("tp:lbu_16", got, 32'h0000_00FF);
    do_req("lh_16", 1'b0, 3'b001, 32'h16, 32'd0, 0, got);  check_val("tp:lh_16", got, 32'hFFFF_80FF);
    do_req("lhu_16", 1'b0, 3'b101, 32'h16, 32'd0, 0, got); check_val("tp:lhu_16", got, 32'h0000_80FF);
    do_req("lw_hold", 1'b0, 3'b010, 32'h14, 32'd0, 5, got); check_val("tp:lw_hold", got, 32'h80FF_7F01);

    poke(3, 32'h1122_3344);
    do_req("sb_0d", 1'b1, 3'b000, 32'h0D, 32'hAAAA_AA55, 0, got);
    check_val("tp:sb_mem", mem[3], 32'h1122_5544);
    poke(3, 32'h1122_3344);
    do_req("sh_0e", 1'b1, 3'b001, 32'h0E, 32'h0000_BEEF, 0, got);
    check_val("tp:sh_mem", mem[3], 32'hBEEF_3344);
    do_req("sw_0c", 1'b1, 3'b010, 32'h0C, 32'hDEAD_BEEF, 0, got);
    check_val("tp:sw_mem", mem[3], 32'hDEAD_BEEF);
    do_req("lw_02", 1'b0, 3'b010, 32'h02, 32'd0, 0, got);   check_val("tp:lw_02_data", got, 32'd0);
    do_req("lh_1001", 1'b0, 3'b001, 32'h1001, 32'd0, 0, got);
    do_req("st_f3_4", 1'b1, 3'b100, 32'h10, 32'h1234_5678, 0, got);

    // Reset dropped into the read half of a read-modify-write.
    poke(3, 32'h1122_3344);
    wr0 = wr_cnt;
    @(negedge clock);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
    req_address = 32'h0D; req_store_data = 32'hAAAA_AA55;
    @(negedge clock);
    req_valid = 1'b0;
    check_val("rstmid:in_rmw", {31'd0, mem_read_enable}, 32'd1);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_val("rstmid:no_write", wr_cnt - wr0, 32'd0);
    check_val("rstmid:mem", mem[3], 32'h1122_3344);
    check_val("rstmid:resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rstmid:req_ready", {31'd0, req_ready}, 32'd1);

    for (int t = 0; t < 200; t++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      a = 32'h1000 + $urandom_range(0, 4095);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, 127);
      do_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             int'($urandom_range(0, 2)), got);
    end

    check_val("no_rd_wr_overlap", both_cnt, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
